lda_count_update: RTL and testbench
===================================

# lda_count_update

Gibbs-sampling count maintenance stage placed directly downstream of `sample_word`. For each token it consumes the sampled topic and applies the count move old-topic → new-topic. The move is a saturating read-modify-write on two external count RAMs: word-topic `nw` and doc-topic `nd`. The block also keeps the per-topic totals `nwsum` in an internal register file and exposes them through a combinational read port back to the sampler. An init mode loads the initial random assignments by increment only.

## Interface
Parameters:
- `NUM_TOPICS`, 16: number of topics; equals 2^`NUM_TOPICS_LOG`.
- `NUM_TOPICS_LOG`, 4: topic index width.
- `WORD_W`, 14: vocabulary index width.
- `DOC_W`, 10: document index width.
- `CNT_W`, 16: count width for `nw`, `nd` and `nwsum` entries.

Ports:
- `clk`  in  1  single clock, all logic on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `i_start`  in  1  one-cycle request; sampled only in IDLE.
- `i_init`  in  1  qualifies `i_start`: 1 = increment-only (no old topic).
- `i_word`  in  `WORD_W`  token word index.
- `i_doc`  in  `DOC_W`  token document index.
- `i_topic_old`  in  `NUM_TOPICS_LOG`  topic before sampling.
- `i_topic_new`  in  `NUM_TOPICS_LOG`  topic from `sample_word` `o_topic_new[NUM_TOPICS_LOG-1:0]`.
- `o_nw_addr`  out  `WORD_W+NUM_TOPICS_LOG`  `nw` address = {word, topic}.
- `o_nw_wen`  out  1  `nw` write enable.
- `o_nw_wdata`  out  `CNT_W`  `nw` write data.
- `i_nw_rdata`  in  `CNT_W`  `nw` read data, one-cycle latency.
- `o_nd_addr`  out  `DOC_W+NUM_TOPICS_LOG`  `nd` address = {doc, topic}.
- `o_nd_wen`  out  1  `nd` write enable.
- `o_nd_wdata`  out  `CNT_W`  `nd` write data.
- `i_nd_rdata`  in  `CNT_W`  `nd` read data, one-cycle latency.
- `i_sum_topic`  in  `NUM_TOPICS_LOG`  `nwsum` read index.
- `o_sum`  out  `CNT_W`  `nwsum[i_sum_topic]`, combinational.
- `o_busy`  out  1  high whenever state ≠ IDLE.
- `o_done`  out  1  one-cycle pulse when the update completes.
- `o_underflow`  out  1  sticky: a decrement hit 0.
- `o_overflow`  out  1  sticky: an increment hit all-ones.

## Operation
- States: IDLE, RD_OLD, WR_OLD, RD_NEW, WR_NEW, DONE.
- IDLE: when `i_start` is high, latch word, doc, old, new and init.
  - If init: go to RD_NEW.
  - Else if old == new: go to DONE. No RAM or `nwsum` access.
  - Else: go to RD_OLD.
- RD_OLD: drive addresses {word,old} and {doc,old}, wen = 0. Next state WR_OLD.
- WR_OLD: same addresses, wen = 1 on both RAMs.
  - wdata = rdata − 1; if rdata == 0, write 0 and set `o_underflow`.
  - `nwsum[old]` decrements with the same saturation rule.
  - Next state RD_NEW.
- RD_NEW: drive addresses {word,new} and {doc,new}, wen = 0. Next state WR_NEW.
- WR_NEW: wen = 1; wdata = rdata + 1, saturating at 2^`CNT_W`−1 and setting `o_overflow`. `nwsum[new]` increments with the same rule. Next state DONE.
- DONE: `o_done` = 1 for one cycle, then IDLE.
- `i_start` outside IDLE is ignored; no queueing.
- Both RAMs are always accessed in lockstep, same cycle.
- `o_sum` reflects an `nwsum` write from the cycle after the write edge.
- Flags clear only on `rst`.
- In IDLE, RD_* and DONE, wen = 0. Addresses hold their last value outside RD/WR states.

## Timing
- Let cycle 0 be the cycle in which `i_start` is sampled.
- Normal move: RD_OLD in cycle 1, WR_OLD 2, RD_NEW 3, WR_NEW 4, `o_done` in cycle 5. The next start is accepted in cycle 6.
- Init: RD_NEW in cycle 1, WR_NEW 2, `o_done` in 3.
- old == new: `o_done` in cycle 1.
- `o_busy` is high from cycle 1 through the `o_done` cycle inclusive.
- Read data is used in the cycle following the address cycle. The RAM must have 1-cycle read latency and no output register.
- Reset values: all outputs 0, including addresses and wdata; state IDLE; all `nwsum` entries 0.
- `rst` mid-operation: wen drops asynchronously. The in-flight update is abandoned (a completed WR_OLD is not rolled back). External RAM contents are untouched.

## Test plan
- Normal move. Reset; nw[5,3]=4, nw[5,7]=9, nd[2,3]=1, nd[2,7]=0; start word=5 doc=2 old=3 new=7 → writes nw[5,3]=3, nd[2,3]=0 in cycle 2; nw[5,7]=10, nd[2,7]=1 in cycle 4; `o_done` in cycle 5; `nwsum[7]`=1, `nwsum[3]`=0 with `o_underflow`=1.
- Init loading. Init start ×3 with new=0 → `nwsum[0]`=3, nw[word,0] increments by 1 each time, `o_done` 3 cycles after each start.
- Equal topics. old=new=9 → no wen pulses, `o_done` in cycle 1, `nwsum` unchanged.
- Saturation. nw[1,2]=0xFFFF on an init to topic 2 → writes 0xFFFF, `o_overflow`=1. nd[x,old]=0 → writes 0, `o_underflow`=1.
- Busy rejection. Second `i_start` in cycle 2 → ignored, exactly one `o_done`, `o_busy` stays high cycles 1-5.
- Reset mid-operation. Assert `rst` during WR_NEW → wen low immediately, `o_busy`=0, `o_sum` for all topics reads 0, and the next start behaves as after a fresh reset.

Source files
------------

// File: rtl/lda_count_update.sv
// Count-move stage for the LDA Gibbs sampler: saturating old->new topic update
// on the external nw/nd count RAMs plus the internal per-topic nwsum totals.
module lda_count_update #(
    parameter int NUM_TOPICS     = 16,
    parameter int NUM_TOPICS_LOG = 4,
    parameter int WORD_W         = 14,
    parameter int DOC_W          = 10,
    parameter int CNT_W          = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             i_start,
    input  logic                             i_init,
    input  logic [WORD_W-1:0]                i_word,
    input  logic [DOC_W-1:0]                 i_doc,
    input  logic [NUM_TOPICS_LOG-1:0]        i_topic_old,
    input  logic [NUM_TOPICS_LOG-1:0]        i_topic_new,
    output logic [WORD_W+NUM_TOPICS_LOG-1:0] o_nw_addr,
    output logic                             o_nw_wen,
    output logic [CNT_W-1:0]                 o_nw_wdata,
    input  logic [CNT_W-1:0]                 i_nw_rdata,
    output logic [DOC_W+NUM_TOPICS_LOG-1:0]  o_nd_addr,
    output logic                             o_nd_wen,
    output logic [CNT_W-1:0]                 o_nd_wdata,
    input  logic [CNT_W-1:0]                 i_nd_rdata,
    input  logic [NUM_TOPICS_LOG-1:0]        i_sum_topic,
    output logic [CNT_W-1:0]                 o_sum,
    output logic                             o_busy,
    output logic                             o_done,
    output logic                             o_underflow,
    output logic                             o_overflow
);

    typedef enum logic [2:0] {
        IDLE,
        RD_OLD,
        WR_OLD,
        RD_NEW,
        WR_NEW,
        DONE
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t                    state;
    logic [WORD_W-1:0]         word_q;
    logic [DOC_W-1:0]          doc_q;
    logic [NUM_TOPICS_LOG-1:0] old_q;
    logic [NUM_TOPICS_LOG-1:0] new_q;
    logic [CNT_W-1:0]          nwsum [NUM_TOPICS];

    logic [CNT_W-1:0] sum_old;
    logic [CNT_W-1:0] sum_new;

    function automatic logic [CNT_W-1:0] sat_dec(input logic [CNT_W-1:0] v);
        return (v == '0) ? '0 : v - 1'b1;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? CNT_MAX : v + 1'b1;
    endfunction

    assign sum_old = nwsum[old_q];
    assign sum_new = nwsum[new_q];
    assign o_sum   = nwsum[i_sum_topic];

    // Write data is formed straight from the RAM read data, which only becomes
    // valid in the cycle after the address cycle.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        o_nw_wdata = '0;
        o_nd_wdata = '0;
        if (state == WR_OLD) begin
            o_nw_wdata = sat_dec(i_nw_rdata);
            o_nd_wdata = sat_dec(i_nd_rdata);
        end else if (state == WR_NEW) begin
            o_nw_wdata = sat_inc(i_nw_rdata);
            o_nd_wdata = sat_inc(i_nd_rdata);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            word_q      <= '0;
            doc_q       <= '0;
            old_q       <= '0;
            new_q       <= '0;
            o_nw_addr   <= '0;
            o_nd_addr   <= '0;
            o_nw_wen    <= 1'b0;
            o_nd_wen    <= 1'b0;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
            o_underflow <= 1'b0;
            o_overflow  <= 1'b0;
            // NOTE: nwsum is a flop register file, so it is cleared by reset like any other state.
            for (int i = 0; i < NUM_TOPICS; i++) begin
                nwsum[i] <= '0;
            end
        end else begin
            // NOTE: sequential state uses non-blocking assignments only.
            o_done   <= 1'b0;
            o_nw_wen <= 1'b0;
            o_nd_wen <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_start) begin
                        word_q <= i_word;
                        doc_q  <= i_doc;
                        old_q  <= i_topic_old;
                        new_q  <= i_topic_new;
                        o_busy <= 1'b1;
                        if (i_init) begin
                            o_nw_addr <= {i_word, i_topic_new};
                            o_nd_addr <= {i_doc, i_topic_new};
                            state     <= RD_NEW;
                        end else if (i_topic_old == i_topic_new) begin
                            o_done <= 1'b1;
                            state  <= DONE;
                        end else begin
                            o_nw_addr <= {i_word, i_topic_old};
                            o_nd_addr <= {i_doc, i_topic_old};
                            state     <= RD_OLD;
                        end
                    end
                end
                RD_OLD: begin
                    o_nw_wen <= 1'b1;
                    o_nd_wen <= 1'b1;
                    state    <= WR_OLD;
                end
                WR_OLD: begin
                    if (i_nw_rdata == '0 || i_nd_rdata == '0 || sum_old == '0) begin
                        o_underflow <= 1'b1;
                    end
                    nwsum[old_q] <= sat_dec(sum_old);
                    o_nw_addr    <= {word_q, new_q};
                    o_nd_addr    <= {doc_q, new_q};
                    state        <= RD_NEW;
                end
                RD_NEW: begin
                    o_nw_wen <= 1'b1;
                    o_nd_wen <= 1'b1;
                    state    <= WR_NEW;
                end
                WR_NEW: begin
                    if (i_nw_rdata == CNT_MAX || i_nd_rdata == CNT_MAX || sum_new == CNT_MAX) begin
                        o_overflow <= 1'b1;
                    end
                    nwsum[new_q] <= sat_inc(sum_new);
                    o_done       <= 1'b1;
                    state        <= DONE;
                end
                DONE: begin
                    o_busy <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lda_count_update.sv
// Randomized bench for lda_count_update: count RAM models, a per-token
// reference model of the count move, and cycle-accurate handshake checks.
module tb_lda_count_update;

    localparam int NT = 16;
    localparam int TL = 4;
    localparam int WW = 14;
    localparam int DW = 10;
    localparam int CW = 16;

    logic clk = 1'b0;
    logic rst;
    logic i_start, i_init;
    logic [WW-1:0] i_word;
    logic [DW-1:0] i_doc;
    logic [TL-1:0] i_topic_old, i_topic_new, i_sum_topic;
    logic [WW+TL-1:0] o_nw_addr;
    logic [DW+TL-1:0] o_nd_addr;
    logic o_nw_wen, o_nd_wen;
    logic [CW-1:0] o_nw_wdata, o_nd_wdata, o_sum;
    logic [CW-1:0] i_nw_rdata, i_nd_rdata;
    logic o_busy, o_done, o_underflow, o_overflow;

    always #5 clk = ~clk;

    lda_count_update #(
        .NUM_TOPICS(NT), .NUM_TOPICS_LOG(TL), .WORD_W(WW), .DOC_W(DW), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst(rst), .i_start(i_start), .i_init(i_init),
        .i_word(i_word), .i_doc(i_doc), .i_topic_old(i_topic_old), .i_topic_new(i_topic_new),
        .o_nw_addr(o_nw_addr), .o_nw_wen(o_nw_wen), .o_nw_wdata(o_nw_wdata), .i_nw_rdata(i_nw_rdata),
        .o_nd_addr(o_nd_addr), .o_nd_wen(o_nd_wen), .o_nd_wdata(o_nd_wdata), .i_nd_rdata(i_nd_rdata),
        .i_sum_topic(i_sum_topic), .o_sum(o_sum), .o_busy(o_busy), .o_done(o_done),
        .o_underflow(o_underflow), .o_overflow(o_overflow)
    );

    // External count RAMs: read-first, one-cycle read latency, plus a preload port.
    bit [CW-1:0] nw_mem [0:(1<<(WW+TL))-1];
    bit [CW-1:0] nd_mem [0:(1<<(DW+TL))-1];
    logic        pl_en = 1'b0;
    logic        pl_nd = 1'b0;
    logic [17:0] pl_addr = '0;
    logic [CW-1:0] pl_data = '0;

    always @(posedge clk) begin
        i_nw_rdata <= nw_mem[o_nw_addr];
        i_nd_rdata <= nd_mem[o_nd_addr];
        if (o_nw_wen) nw_mem[o_nw_addr] <= o_nw_wdata;
        if (o_nd_wen) nd_mem[o_nd_addr] <= o_nd_wdata;
        if (pl_en && !pl_nd) nw_mem[pl_addr] <= pl_data;
        if (pl_en && pl_nd) nd_mem[pl_addr[DW+TL-1:0]] <= pl_data;
    end

    // Reference model: counts per (word,topic), (doc,topic), per-topic totals, flags.
    int unsigned exp_nw [0:(1<<(WW+TL))-1];
    int unsigned exp_nd [0:(1<<(DW+TL))-1];
    int unsigned exp_sum [NT];
    bit exp_uf, exp_ovf;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int nwk(input int w, input int t);
        return w * NT + t;
    endfunction

    function automatic int ndk(input int d, input int t);
        return d * NT + t;
    endfunction

    function automatic void model_dec(inout int unsigned v);
        if (v == 0) exp_uf = 1'b1;
        else v = v - 1;
    endfunction

    function automatic void model_inc(inout int unsigned v);
        if (v == 32'hFFFF) exp_ovf = 1'b1;
        else v = v + 1;
    endfunction

    task automatic preload(input bit nd, input int addr, input int unsigned val);
        @(negedge clk);
        pl_en = 1'b1; pl_nd = nd; pl_addr = 18'(addr); pl_data = CW'(val);
        @(negedge clk);
        pl_en = 1'b0;
        if (nd) exp_nd[addr] = val;
        else exp_nw[addr] = val;
    endtask

    task automatic check_sums(input string tag);
        for (int t = 0; t < NT; t++) begin
            i_sum_topic = TL'(t);
            #1;
            check(tag, {16'h0, o_sum}, exp_sum[t]);
        end
    endtask

    // Issue one token. rst_at > 0 asserts reset in that cycle of the operation.
    task automatic run_op(input bit init, input int w, input int d, input int t_old,
                          input int t_new, input bit poke, input int rst_at);
        int lat, wmask_exp, wmask, dones, done_cyc, busy_bad, lock_bad;
        bit did_rst;
        lat = init ? 3 : ((t_old == t_new) ? 1 : 5);
        wmask_exp = init ? (1 << 2) : ((t_old == t_new) ? 0 : ((1 << 2) | (1 << 4)));
        wmask = 0; dones = 0; done_cyc = 0; busy_bad = 0; lock_bad = 0; did_rst = 1'b0;
        @(negedge clk);
        i_start = 1'b1; i_init = init;
        i_word = WW'(w); i_doc = DW'(d);
        i_topic_old = TL'(t_old); i_topic_new = TL'(t_new);
        for (int k = 1; k <= 8 && !did_rst; k++) begin
            @(negedge clk);
            if (k == 1) i_start = 1'b0;
            if (poke && k == 2) begin
                i_start = 1'b1; i_init = 1'($urandom);
                i_word = WW'($urandom_range(0, 7)); i_topic_new = TL'($urandom);
            end
            if (k == 3) i_start = 1'b0;
            if (k == rst_at) begin
                rst = 1'b1;
                #1;
                check("rst_nw_wen", {31'h0, o_nw_wen}, 0);
                check("rst_nd_wen", {31'h0, o_nd_wen}, 0);
                check("rst_busy", {31'h0, o_busy}, 0);
                did_rst = 1'b1;
            end else begin
                if (o_done) begin dones++; done_cyc = k; end
                if (o_nw_wen) wmask |= (1 << k);
                if (o_nw_wen != o_nd_wen) lock_bad++;
                if (o_busy != (k <= lat)) busy_bad++;
            end
        end
        if (!init && t_old != t_new) begin
            model_dec(exp_nw[nwk(w, t_old)]);
            model_dec(exp_nd[ndk(d, t_old)]);
            model_dec(exp_sum[t_old]);
        end
        if (did_rst) begin
            foreach (exp_sum[t]) exp_sum[t] = 0;
            exp_uf = 1'b0; exp_ovf = 1'b0;
            check_sums("rst_sum");
            @(negedge clk);
            rst = 1'b0;
        end else begin
            if (init || t_old != t_new) begin
                model_inc(exp_nw[nwk(w, t_new)]);
                model_inc(exp_nd[ndk(d, t_new)]);
                model_inc(exp_sum[t_new]);
            end
            check("done_cycle", done_cyc, lat);
            check("done_count", dones, 1);
            check("wen_cycles", wmask, wmask_exp);
            check("busy_window", busy_bad, 0);
            check("wen_lockstep", lock_bad, 0);
            check_sums("nwsum");
        end
        check("nw_old", {16'h0, nw_mem[nwk(w, t_old)]}, exp_nw[nwk(w, t_old)]);
        check("nd_old", {16'h0, nd_mem[ndk(d, t_old)]}, exp_nd[ndk(d, t_old)]);
        check("nw_new", {16'h0, nw_mem[nwk(w, t_new)]}, exp_nw[nwk(w, t_new)]);
        check("nd_new", {16'h0, nd_mem[ndk(d, t_new)]}, exp_nd[ndk(d, t_new)]);
        check("underflow", {31'h0, o_underflow}, {31'h0, exp_uf});
        check("overflow", {31'h0, o_overflow}, {31'h0, exp_ovf});
    endtask

    function automatic int unsigned pick_val();
        case ($urandom_range(0, 4))
            0: return 0;
            1: return 32'hFFFF;
            2: return 32'hFFFE;
            3: return 1;
            default: return $urandom_range(0, 32'hFFFF);
        endcase
    endfunction

    initial begin
        int w, d, to, tn;
        bit init;
        exp_uf = 1'b0; exp_ovf = 1'b0;
        foreach (exp_sum[t]) exp_sum[t] = 0;
        rst = 1'b1; i_start = 1'b0; i_init = 1'b0;
        i_word = '0; i_doc = '0; i_topic_old = '0; i_topic_new = '0; i_sum_topic = '0;
        repeat (2) @(negedge clk);
        check("reset_nw_addr", {14'h0, o_nw_addr}, 0);
        check("reset_nd_addr", {18'h0, o_nd_addr}, 0);
        check("reset_wdata", {o_nw_wdata, o_nd_wdata}, 0);
        check("reset_ctrl", {26'h0, o_nw_wen, o_nd_wen, o_busy, o_done, o_underflow, o_overflow}, 0);
        check_sums("reset_sum");
        rst = 1'b0;

        // Normal move from the worked example.
        preload(0, nwk(5, 3), 4); preload(0, nwk(5, 7), 9);
        preload(1, ndk(2, 3), 1); preload(1, ndk(2, 7), 0);
        run_op(0, 5, 2, 3, 7, 0, 0);
        // Init loading, three times into topic 0.
        for (int i = 0; i < 3; i++) run_op(1, 4, 1, 0, 0, 0, 0);
        // Equal topics.
        run_op(0, 6, 3, 9, 9, 0, 0);
        // Saturation on increment and decrement.
        preload(0, nwk(1, 2), 32'hFFFF);
        run_op(1, 1, 0, 0, 2, 0, 0);
        preload(1, ndk(3, 5), 0);
        run_op(0, 2, 3, 5, 6, 0, 0);
        // Busy rejection of a second start.
        run_op(0, 3, 1, 1, 4, 1, 0);
        // Reset during WR_NEW, then a fresh operation.
        preload(0, nwk(7, 8), 20); preload(1, ndk(1, 8), 20);
        run_op(0, 7, 1, 8, 10, 0, 4);
        run_op(0, 7, 1, 10, 8, 0, 0);

        for (int n = 0; n < 40; n++) begin
            init = ($urandom_range(0, 3) == 0);
            w = $urandom_range(0, 7); d = $urandom_range(0, 3);
            to = $urandom_range(0, NT - 1);
            tn = ($urandom_range(0, 4) == 0) ? to : $urandom_range(0, NT - 1);
            if ($urandom_range(0, 1) == 1) preload(0, nwk(w, to), pick_val());
            if ($urandom_range(0, 1) == 1) preload(1, ndk(d, tn), pick_val());
            run_op(init, w, d, to, tn, (!init && to != tn && $urandom_range(0, 2) == 0), 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
